mc_control_fsm: RTL

- Multicycle main control FSM; the producer side of the 3-bit ALU control interface.
- Sequences fetch, decode, execute, memory and writeback for a MIPS-subset core.
- Drives datapath mux selects, write enables, the memory request handshake and `alu_control`, which feeds the ALU directly.
- Consumes opcode/funct from the instruction register and the ALU zero flag.

---
 rtl/mc_control_fsm.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset main control FSM: drives datapath selects, strobes, memory handshake and alu_control.
// Zero-wait latency lw 5, sw/R/addi 4, beq/j 3 cycles; FETCH, MEMRD and MEMWR stall while mem_ready is low.
module mc_control_fsm #(
   parameter bit ERROR_STICKY = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_en,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_control,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       instr_done,
   output logic       illegal
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;
   localparam logic [2:0] ALU_NOR = 3'b101;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXECUTE = 4'd7,
      S_ALUWB   = 4'd8,
      S_BRANCH  = 4'd9,
      S_ADDIEX  = 4'd10,
      S_ADDIWB  = 4'd11,
      S_JUMP    = 4'd12,
      S_ERROR   = 4'd13
   } state_t;

   state_t state_q, state_d;

   function automatic logic funct_supported(input logic [5:0] f);
      case (f)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: funct_supported = 1'b1;
         default:                                       funct_supported = 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] funct_to_alu(input logic [5:0] f);
      case (f)
         FN_SUB:  funct_to_alu = ALU_SUB;
         FN_AND:  funct_to_alu = ALU_AND;
         FN_OR:   funct_to_alu = ALU_OR;
         FN_NOR:  funct_to_alu = ALU_NOR;
         FN_SLT:  funct_to_alu = ALU_SLT;
         default: funct_to_alu = ALU_ADD;
      endcase
   endfunction

   // Async reset forces IDLE, so every state-decoded strobe drops in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = funct_supported(funct) ? S_EXECUTE : S_ERROR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_ERROR;
            endcase
         end
         S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR:   if (mem_ready) state_d = S_FETCH;
         S_EXECUTE: state_d = S_ALUWB;
         S_ALUWB:   state_d = S_FETCH;
         S_BRANCH:  state_d = S_FETCH;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_ADDIWB:  state_d = S_FETCH;
         S_JUMP:    state_d = S_FETCH;
         S_ERROR:   state_d = ERROR_STICKY ? S_ERROR : S_FETCH;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      iord        = 1'b0;
      ir_write    = 1'b0;
      pc_en       = 1'b0;
      pc_src      = 2'b00;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_control = ALU_ADD;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      instr_done  = 1'b0;
      illegal     = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_en     = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            mem_req    = 1'b1;
            mem_write  = 1'b1;
            iord       = 1'b1;
            instr_done = mem_ready;
         end
         S_EXECUTE: begin
            alu_src_a   = 1'b1;
            alu_control = funct_to_alu(funct);
         end
         S_ALUWB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a   = 1'b1;
            alu_control = ALU_SUB;
            pc_src      = 2'b01;
            pc_en       = zero;
            instr_done  = 1'b1;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_ADDIWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_JUMP: begin
            pc_src     = 2'b10;
            pc_en      = 1'b1;
            instr_done = 1'b1;
         end
         S_ERROR: begin
            illegal = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule
